gimli_stream_buffer_in: RTL and testbench

Narrow-to-wide input packer in front of the Gimli core. It accepts 32-bit byte-sized words from the host stream and packs them little-endian into 128-bit blocks, each tagged with a byte count and a last flag. It is the counterpart of the wide-to-narrow output buffer and uses the same valid/ready, size and last conventions, so the core sees one block per absorb or squeeze step.

---
 rtl/gimli_stream_pkg.sv | 28 ++
 rtl/gimli_stream_buffer_in.sv | 102 ++++++++++
 tb/tb_gimli_stream_buffer_in.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gimli_stream_pkg.sv
// Shared types and constants for the Gimli stream buffers.
// Holds the packer state encoding, block geometry and the byte-mask helper.
package gimli_stream_pkg;

    typedef enum logic {
        FILL = 1'b0,
        OUT  = 1'b1
    } state_e;

    localparam int DIN_W           = 32;
    localparam int DOUT_W          = 128;
    localparam int BYTES_PER_DIN   = 4;
    localparam int BYTES_PER_DOUT  = 16;
    localparam int WORDS_PER_BLOCK = DOUT_W / DIN_W;

    // Keeps bytes below nbytes, zeroes bytes at or above it.
    function automatic logic [DIN_W-1:0] byte_mask(input logic [2:0] nbytes);
        logic [DIN_W-1:0] m;
        m = '0;
        for (int i = 0; i < BYTES_PER_DIN; i++) begin
            if (3'(i) < nbytes) begin
                m[8*i +: 8] = 8'hFF;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/gimli_stream_buffer_in.sv
// Narrow-to-wide packer: 32-bit host words into little-endian 128-bit blocks.
// state | meaning:  FILL | accumulating words into the block;  OUT | block presented, waiting for dout_ready
module gimli_stream_buffer_in
    import gimli_stream_pkg::*;
#(
    parameter int DIN_WIDTH       = 32,
    parameter int DIN_SIZE_WIDTH  = 2,
    parameter int DOUT_WIDTH      = 128,
    parameter int DOUT_SIZE_WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DIN_WIDTH-1:0]       din,
    input  logic [DIN_SIZE_WIDTH:0]    din_size,
    input  logic                       din_last,
    input  logic                       din_valid,
    output logic                       din_ready,
    output logic [DOUT_WIDTH-1:0]      dout,
    output logic [DOUT_SIZE_WIDTH:0]   dout_size,
    output logic                       dout_valid,
    input  logic                       dout_ready,
    output logic                       dout_last,
    output logic [DOUT_SIZE_WIDTH:0]   size
);

    localparam int KW = DOUT_SIZE_WIDTH - DIN_SIZE_WIDTH;
    localparam logic [DIN_SIZE_WIDTH:0]  DIN_FULL  = (DIN_SIZE_WIDTH+1)'(BYTES_PER_DIN);
    localparam logic [DOUT_SIZE_WIDTH:0] DOUT_FULL = (DOUT_SIZE_WIDTH+1)'(BYTES_PER_DOUT);

    state_e                   state_q, state_d;
    logic [DOUT_WIDTH-1:0]    buf_q, buf_d;
    logic [DOUT_SIZE_WIDTH:0] size_q, size_d;
    logic [KW-1:0]            k_q, k_d;
    logic                     last_q, last_d;

    logic [DIN_SIZE_WIDTH:0]  dsz;
    logic [DIN_WIDTH-1:0]     word;
    logic                     accept;
    logic                     out_fire;
    logic                     no_op;

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        size_d  = size_q;
        k_d     = k_q;
        last_d  = last_q;

        dsz        = (din_size > DIN_FULL) ? DIN_FULL : din_size;
        word       = din & byte_mask(dsz);
        din_ready  = rst && ((state_q == FILL) || dout_ready);
        dout_valid = (state_q == OUT);
        out_fire   = dout_valid && dout_ready;
        accept     = din_valid && din_ready;
        no_op      = (dsz == '0) && !din_last;

        if (out_fire) begin
            state_d = FILL;
            buf_d   = '0;
            size_d  = '0;
            k_d     = '0;
            last_d  = 1'b0;
        end

        // Accepting in OUT implies out_fire, so the word lands in a fresh block.
        if (accept && !no_op) begin
            for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
                if (k_d == KW'(i)) begin
                    buf_d[i*DIN_WIDTH +: DIN_WIDTH] = word;
                end
            end
            size_d = size_d + (DOUT_SIZE_WIDTH+1)'(dsz);
            k_d    = k_d + KW'(1);
            last_d = din_last;
            if ((size_d == DOUT_FULL) || din_last || (dsz < DIN_FULL)) begin
                state_d = OUT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FILL;
            buf_q   <= '0;
            size_q  <= '0;
            k_q     <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            size_q  <= size_d;
            k_q     <= k_d;
            last_q  <= last_d;
        end
    end

    assign dout      = buf_q;
    assign dout_size = size_q;
    assign dout_last = last_q;
    assign size      = size_q;

endmodule

// File: tb/tb_gimli_stream_buffer_in.sv
// Self-checking bench for gimli_stream_buffer_in against a byte-queue block model.
module tb_gimli_stream_buffer_in;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [31:0]  din = '0;
    logic [2:0]   din_size = '0;
    logic         din_last = 1'b0;
    logic         din_valid = 1'b0;
    logic         din_ready;
    logic [127:0] dout;
    logic [4:0]   dout_size;
    logic         dout_valid;
    logic         dout_ready = 1'b0;
    logic         dout_last;
    logic [4:0]   size;

    gimli_stream_buffer_in dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_size   (din_size),
        .din_last   (din_last),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_size  (dout_size),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_last  (dout_last),
        .size       (size)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [127:0] d;
        logic [4:0]   s;
        logic         l;
    } block_t;

    typedef struct packed {
        logic [31:0] d;
        logic [2:0]  s;
        logic        l;
    } word_t;

    int n_checks = 0;
    int n_errs   = 0;
    int n_last   = 0;

    block_t      exp_q[$];
    logic [7:0]  acc[$];
    word_t       pend[$];

    logic         prev_stall = 1'b0;
    logic [127:0] prev_dout;
    logic [4:0]   prev_size;
    logic         prev_last;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: gather accepted bytes, emit a block on 16 bytes, last, or a short word.
    function automatic void model_word(input logic [31:0] d, input logic [2:0] s, input logic l);
        int     n;
        block_t b;
        n = (s > 3'd4) ? 4 : int'(s);
        if (n == 0 && !l) return;
        for (int i = 0; i < n; i++) acc.push_back(d[8*i +: 8]);
        if (acc.size() == 16 || l || n < 4) begin
            b.d = '0;
            for (int i = 0; i < acc.size(); i++) b.d[8*i +: 8] = acc[i];
            b.s = 5'(acc.size());
            b.l = l;
            exp_q.push_back(b);
            acc.delete();
        end
    endfunction

    // One clock: drive at the falling edge, sample 1 unit later, predict the coming rising edge.
    task automatic cycle(input bit v, input logic [31:0] d, input logic [2:0] s, input bit l,
                         input bit rdy, output bit in_acc, output bit out_acc);
        block_t b;
        @(negedge clk);
        din_valid  = v;
        din        = d;
        din_size   = s;
        din_last   = l;
        dout_ready = rdy;
        #1;
        if (prev_stall) begin
            chk("hold_valid", dout_valid, 1);
            chk("hold_dout", dout, prev_dout);
            chk("hold_size", dout_size, prev_size);
            chk("hold_last", dout_last, prev_last);
        end
        in_acc  = v && din_ready;
        out_acc = dout_valid && rdy;
        if (out_acc) begin
            chk("sb_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                b = exp_q.pop_front();
                chk("sb_dout", dout, b.d);
                chk("sb_size", dout_size, b.s);
                chk("sb_last", dout_last, b.l);
            end
            if (dout_last) n_last++;
        end
        if (in_acc) model_word(d, s, l);
        prev_stall = dout_valid && !rdy;
        prev_dout  = dout;
        prev_size  = dout_size;
        prev_last  = dout_last;
    endtask

    task automatic send(input logic [31:0] d, input logic [2:0] s, input bit l, input bit rdy);
        bit ia, oa;
        ia = 0;
        for (int t = 0; t < 50; t++) begin
            cycle(1, d, s, l, rdy, ia, oa);
            if (ia) break;
        end
        chk("send_accept", ia, 1);
    endtask

    always @(posedge clk) begin
        if (rst && din_valid) begin
            assert (din_size <= 3'd4) else $error("illegal din_size %0d", din_size);
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit           ia, oa;
        logic [31:0]  w [4];
        logic [127:0] full;
        int           len, cyc;
        word_t        wd;
        bit           v;

        // Reset state with both handshake inputs pushed high
        rst = 1'b0;
        din_valid = 1'b1;
        dout_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_din_ready", din_ready, 0);
        chk("rst_size", size, 0);
        chk("rst_dout", dout, 0);
        chk("rst_last", dout_last, 0);
        @(negedge clk);
        din_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("post_rst_ready", din_ready, 1);

        // Full four-word message
        send(32'h03020100, 3'd4, 0, 1);
        send(32'h07060504, 3'd4, 0, 1);
        send(32'h0B0A0908, 3'd4, 0, 1);
        send(32'h0F0E0D0C, 3'd4, 1, 1);
        cycle(0, 32'h0, 3'd0, 0, 1, ia, oa);
        chk("t1_latency", oa, 1);
        chk("t1_dout", dout, 128'h0F0E0D0C_0B0A0908_07060504_03020100);
        chk("t1_size", dout_size, 16);
        chk("t1_last", dout_last, 1);

        // Short word closes the block
        send(32'hAABBCCDD, 3'd4, 0, 1);
        send(32'h11223344, 3'd2, 0, 1);
        cycle(0, 32'h0, 3'd0, 0, 1, ia, oa);
        chk("t2_valid", oa, 1);
        chk("t2_dout", dout, 128'h00003344_AABBCCDD);
        chk("t2_size", dout_size, 6);
        chk("t2_last", dout_last, 0);

        // Zero-size words
        send(32'hFFFFFFFF, 3'd0, 1, 1);
        cycle(0, 32'h0, 3'd0, 0, 1, ia, oa);
        chk("t3_valid", oa, 1);
        chk("t3_dout", dout, 0);
        chk("t3_size", dout_size, 0);
        chk("t3_last", dout_last, 1);
        send(32'hDEADBEEF, 3'd0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 32'h0, 3'd0, 0, 1, ia, oa);
            chk("t3_no_block", dout_valid, 0);
            chk("t3_size_idle", size, 0);
        end

        // Stall on a full block, then accept with a new word in the same cycle
        for (int i = 0; i < 4; i++) w[i] = $urandom;
        full = {w[3], w[2], w[1], w[0]};
        for (int i = 0; i < 4; i++) send(w[i], 3'd4, 0, 1);
        for (int i = 0; i < 5; i++) begin
            cycle(1, 32'hCAFEF00D, 3'd4, 1, 0, ia, oa);
            chk("t4_stall_ready", din_ready, 0);
            chk("t4_stall_acc", ia, 0);
            chk("t4_stall_dout", dout, full);
        end
        cycle(1, 32'hCAFEF00D, 3'd4, 1, 1, ia, oa);
        chk("t4_in_acc", ia, 1);
        chk("t4_out_acc", oa, 1);
        cycle(0, 32'h0, 3'd0, 0, 1, ia, oa);
        chk("t4_next_valid", oa, 1);
        chk("t4_next_word0", dout[31:0], 32'hCAFEF00D);
        chk("t4_next_upper", dout[127:32], 0);
        chk("t4_next_size", dout_size, 4);
        chk("t4_next_last", dout_last, 1);

        // Reset mid-block discards the partial block
        send(32'h12345678, 3'd4, 0, 1);
        send(32'h9ABCDEF0, 3'd4, 0, 1);
        din_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("t5_rst_size", size, 0);
        chk("t5_rst_valid", dout_valid, 0);
        acc.delete();
        prev_stall = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t5_rel_size", size, 0);
        send(32'h44332211, 3'd4, 0, 1);
        send(32'h88776655, 3'd4, 0, 1);
        send(32'hCCBBAA99, 3'd4, 0, 1);
        send(32'h00FFEEDD, 3'd4, 1, 1);
        cycle(0, 32'h0, 3'd0, 0, 1, ia, oa);
        chk("t5_valid", oa, 1);
        chk("t5_dout", dout, 128'h00FFEEDD_CCBBAA99_88776655_44332211);
        chk("t5_size", dout_size, 16);

        // Randomised messages against the byte-queue model
        chk("pre_rand_sb_empty", exp_q.size(), 0);
        n_last = 0;
        for (int m = 0; m < 1000; m++) begin
            len = $urandom_range(1, 6);
            for (int j = 0; j < len; j++) begin
                wd.d = $urandom;
                wd.s = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 3)) : 3'd4;
                wd.l = (j == len - 1);
                pend.push_back(wd);
            end
        end
        cyc = 0;
        while ((pend.size() > 0 || exp_q.size() > 0) && cyc < 80000) begin
            v = (pend.size() > 0) && ($urandom_range(0, 99) < 70);
            if (v) wd = pend[0];
            else begin
                wd.d = $urandom;
                wd.s = 3'd0;
                wd.l = 1'b0;
            end
            cycle(v, wd.d, wd.s, wd.l, $urandom_range(0, 99) < 70, ia, oa);
            if (ia) void'(pend.pop_front());
            cyc++;
        end
        chk("rand_done_in_budget", cyc < 80000, 1);
        chk("rand_last_count", n_last, 1000);
        chk("rand_sb_empty", exp_q.size(), 0);
        chk("rand_acc_empty", acc.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
